// File: rtl/traffic_pkg.sv
// Shared light codes and phase encodings for the intersection sequencer.
package traffic_pkg;

   typedef enum logic [1:0] {
      RED    = 2'd0,
      YELLOW = 2'd1,
      GREEN  = 2'd2
   } light_e;

   typedef enum logic [2:0] {
      PH_MG  = 3'd0,
      PH_MY  = 3'd1,
      PH_AR1 = 3'd2,
      PH_SG  = 3'd3,
      PH_SY  = 3'd4,
      PH_AR2 = 3'd5
   } phase_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable tick-driven down-counter; bottoms out at 1 and reports it as expired.
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Load wins over counting; the count never drops below 1 so an idle phase stays expired.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (tick && (count_q > CNT_W'(1))) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      count_q <= count_d;
   end

   assign expired = (count_q == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Timed two-street phase sequencer with latched vehicle/pedestrian requests and walk lamp.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int MG_MIN = 20,
   parameter int Y_T    = 4,
   parameter int AR_T   = 2,
   parameter int SG_MAX = 15
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       tick,
   input  logic       side_sensor,
   input  logic       ped_btn,
   output logic [1:0] MainStreet,
   output logic [1:0] SideStreet,
   output logic       walk,
   output logic [2:0] phase
);

   localparam int DUR_MAX = (1 << CNT_W) - 1;

   if (MG_MIN < 1 || MG_MIN > DUR_MAX || Y_T < 1 || Y_T > DUR_MAX ||
       AR_T < 1 || AR_T > DUR_MAX || SG_MAX < 1 || SG_MAX > DUR_MAX) begin : g_bad_duration
      $error("traffic_phase_ctrl: every duration must lie in 1..2^CNT_W-1");
   end

   function automatic logic [CNT_W-1:0] duration(input phase_e ph);
      case (ph)
         PH_MY, PH_SY:   duration = CNT_W'(Y_T);
         PH_AR1, PH_AR2: duration = CNT_W'(AR_T);
         PH_SG:          duration = CNT_W'(SG_MAX);
         default:        duration = CNT_W'(MG_MIN);
      endcase
   endfunction

   phase_e           state_q, state_d;
   logic             side_pend_q, side_pend_d;
   logic             ped_pend_q, ped_pend_d;
   logic             walk_q, walk_d;
   logic [1:0]       main_q, main_d;
   logic [1:0]       side_lt_q, side_lt_d;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             timer_exp;
   logic             done;
   logic             entering_sg;

   assign done = tick && timer_exp;

   always_comb begin
      state_d = state_q;
      case (state_q)
         PH_MG:   if (done && (side_pend_q || ped_pend_q)) state_d = PH_MY;
         PH_MY:   if (done) state_d = PH_AR1;
         PH_AR1:  if (done) state_d = PH_SG;
         PH_SG:   if (tick && (timer_exp || (!side_sensor && !walk_q))) state_d = PH_SY;
         PH_SY:   if (done) state_d = PH_AR2;
         PH_AR2:  if (done) state_d = PH_MG;
         default: state_d = PH_MG;
      endcase

      entering_sg = (state_d == PH_SG) && (state_q != PH_SG);

      // A button press during side green stays queued for the following cycle.
      side_pend_d = side_pend_q | (side_sensor && (state_q != PH_SG));
      ped_pend_d  = ped_pend_q | ped_btn;
      if (entering_sg) begin
         side_pend_d = 1'b0;
         ped_pend_d  = 1'b0;
      end

      walk_d = 1'b0;
      if (entering_sg) begin
         walk_d = ped_pend_q;
      end else if (state_d == PH_SG) begin
         walk_d = walk_q;
      end

      main_d    = RED;
      side_lt_d = RED;
      case (state_d)
         PH_MG:   main_d    = GREEN;
         PH_MY:   main_d    = YELLOW;
         PH_SG:   side_lt_d = GREEN;
         PH_SY:   side_lt_d = YELLOW;
         default: ;
      endcase

      timer_load = !clear_n || (state_d != state_q);
      timer_val  = clear_n ? duration(state_d) : CNT_W'(MG_MIN);
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q     <= PH_MG;
         side_pend_q <= 1'b0;
         ped_pend_q  <= 1'b0;
         walk_q      <= 1'b0;
         main_q      <= GREEN;
         side_lt_q   <= RED;
      end else begin
         state_q     <= state_d;
         side_pend_q <= side_pend_d;
         ped_pend_q  <= ped_pend_d;
         walk_q      <= walk_d;
         main_q      <= main_d;
         side_lt_q   <= side_lt_d;
      end
   end

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clock    (clock),
      .load     (timer_load),
      .load_val (timer_val),
      .tick     (tick),
      .expired  (timer_exp)
   );

   assign MainStreet = main_q;
   assign SideStreet = side_lt_q;
   assign walk       = walk_q;
   assign phase      = state_q;

endmodule
